// File: rtl/xbar_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : xbar_ctrl_pkg
// Purpose  : Shared defaults, derived widths and FSM state type for the
//            crossbar weight sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package xbar_ctrl_pkg;

    localparam int XBAR_SIZE_DFLT = 16;
    localparam int WT_BITS_DFLT   = 16;
    localparam int ROW_W          = XBAR_SIZE_DFLT * WT_BITS_DFLT;
    localparam int ADDR_W         = $clog2(XBAR_SIZE_DFLT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2,
        READ   = 2'd3
    } xbar_ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/xbar_wt_stage.sv
`default_nettype none
// ============================================================================
// Module   : xbar_wt_stage
// Purpose  : Row-addressed staging buffer holding one full weight matrix,
//            presented flattened to the weight memory.
// Revision : 1.0 - initial release
// ============================================================================
module xbar_wt_stage
    import xbar_ctrl_pkg::*;
#(
    parameter int XBAR_SIZE = XBAR_SIZE_DFLT,
    parameter int WT_BITS   = WT_BITS_DFLT
) (
    input  logic                                   clk,
    input  logic                                   clear,
    input  logic                                   wr_en,
    input  logic [$clog2(XBAR_SIZE)-1:0]           row_idx,
    input  logic [XBAR_SIZE*WT_BITS-1:0]           row_data,
    output logic [XBAR_SIZE*XBAR_SIZE*WT_BITS-1:0] matrix
);

    localparam int ROW_BITS = XBAR_SIZE * WT_BITS;
    localparam int IDX_W    = $clog2(XBAR_SIZE);

    generate
        for (genvar r = 0; r < XBAR_SIZE; r++) begin : g_row
            logic [ROW_BITS-1:0] r_row;

            always_ff @(posedge clk) begin
                if (clear) begin
                    r_row <= '0;
                end else if (wr_en && (row_idx == IDX_W'(r))) begin
                    r_row <= row_data;
                end
            end

            assign matrix[r*ROW_BITS +: ROW_BITS] = r_row;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/xbar_wt_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : xbar_wt_ctrl
// Purpose  : Serialises weight-matrix loading/commit and full read sweeps
//            of the crossbar weight memory.
// Revision : 1.0 - initial release
// ============================================================================
module xbar_wt_ctrl
    import xbar_ctrl_pkg::*;
#(
    parameter int XBAR_SIZE = XBAR_SIZE_DFLT,
    parameter int WT_BITS   = WT_BITS_DFLT
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   wr_valid,
    output logic                                   wr_ready,
    input  logic [XBAR_SIZE*WT_BITS-1:0]           wr_row,
    input  logic                                   rd_start,
    output logic                                   prog_wt,
    output logic [XBAR_SIZE*XBAR_SIZE*WT_BITS-1:0] wr_weight,
    output logic [$clog2(XBAR_SIZE)-1:0]           rd_addr,
    output logic                                   rd_valid,
    output logic                                   rd_done,
    output logic                                   busy
);

    localparam int CNT_W = $clog2(XBAR_SIZE);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(XBAR_SIZE - 1);

    xbar_ctrl_state_t r_state;
    xbar_ctrl_state_t w_state_nxt;
    logic [CNT_W-1:0] r_row_cnt;
    logic [CNT_W-1:0] r_rd_addr;
    logic [CNT_W-1:0] w_row_idx;
    logic             r_pending;
    logic             r_rd_done;
    logic             w_wr_ready;
    logic             w_prog;
    logic             w_rd_valid;
    logic             w_accept;
    logic             w_enter_read;

    // A read request seen in IDLE takes the cycle, so no row is accepted then.
    always_comb begin
        w_state_nxt = r_state;
        w_wr_ready  = 1'b0;
        w_prog      = 1'b0;
        w_rd_valid  = 1'b0;
        case (r_state)
            IDLE: begin
                w_wr_ready = !(rd_start || r_pending);
                if (rd_start || r_pending) begin
                    w_state_nxt = READ;
                end else if (wr_valid) begin
                    w_state_nxt = LOAD;
                end
            end
            LOAD: begin
                w_wr_ready = 1'b1;
                if (wr_valid && (r_row_cnt == C_LAST)) begin
                    w_state_nxt = COMMIT;
                end
            end
            COMMIT: begin
                w_prog      = 1'b1;
                w_state_nxt = r_pending ? READ : IDLE;
            end
            READ: begin
                w_rd_valid = 1'b1;
                if (r_rd_addr == C_LAST) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_accept     = wr_valid && w_wr_ready;
    assign w_enter_read = (w_state_nxt == READ) && (r_state != READ);
    assign w_row_idx    = (r_state == IDLE) ? '0 : r_row_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_row_cnt <= '0;
            r_rd_addr <= '0;
            r_pending <= 1'b0;
            r_rd_done <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rd_done <= (r_state == READ) && (r_rd_addr == C_LAST);

            if (w_accept) begin
                r_row_cnt <= (r_state == IDLE) ? CNT_W'(1) : r_row_cnt + CNT_W'(1);
            end

            // Entering READ consumes every request collected so far.
            if (w_enter_read) begin
                r_pending <= 1'b0;
            end else if (rd_start) begin
                r_pending <= 1'b1;
            end

            if (w_enter_read) begin
                r_rd_addr <= '0;
            end else if ((r_state == READ) && (r_rd_addr != C_LAST)) begin
                r_rd_addr <= r_rd_addr + CNT_W'(1);
            end
        end
    end

    xbar_wt_stage #(
        .XBAR_SIZE (XBAR_SIZE),
        .WT_BITS   (WT_BITS)
    ) u_stage (
        .clk      (clk),
        .clear    (reset),
        .wr_en    (w_accept),
        .row_idx  (w_row_idx),
        .row_data (wr_row),
        .matrix   (wr_weight)
    );

    assign wr_ready = w_wr_ready && !reset;
    assign prog_wt  = w_prog && !reset;
    assign rd_valid = w_rd_valid && !reset;
    assign rd_done  = r_rd_done;
    assign rd_addr  = r_rd_addr;
    assign busy     = ((r_state != IDLE) || r_pending) && !reset;

endmodule
`default_nettype wire

// File: tb/tb_xbar_wt_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_xbar_wt_ctrl
// Purpose  : Directed self-checking bench for xbar_wt_ctrl (4x4, 8-bit).
// Revision : 1.0 - initial release
// ============================================================================
module tb_xbar_wt_ctrl;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           wr_valid;
    logic           wr_ready;
    logic [N*W-1:0] wr_row;
    logic           rd_start;
    logic           prog_wt;
    logic [N*N*W-1:0] wr_weight;
    logic [1:0]     rd_addr;
    logic           rd_valid;
    logic           rd_done;
    logic           busy;

    int errors = 0;
    int checks = 0;
    int prog_cnt = 0;
    int done_cnt = 0;

    localparam logic [N*N*W-1:0] C_EXP_A = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    localparam logic [N*N*W-1:0] C_EXP_B = 128'hD3D2D1D0_C3C2C1C0_B7B6B5B4_A3A2A1A0;

    xbar_wt_ctrl #(
        .XBAR_SIZE (N),
        .WT_BITS   (W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_row    (wr_row),
        .rd_start  (rd_start),
        .prog_wt   (prog_wt),
        .wr_weight (wr_weight),
        .rd_addr   (rd_addr),
        .rd_valid  (rd_valid),
        .rd_done   (rd_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (prog_wt) prog_cnt <= prog_cnt + 1;
        if (rd_done) done_cnt <= done_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; wr_valid = 1'b0; wr_row = '0; rd_start = 1'b0;
        step(); step();
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready: got %b want 0", wr_ready); end
        checks++; if ({prog_wt, rd_valid, rd_done, busy} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b want 0000", {prog_wt, rd_valid, rd_done, busy}); end
        checks++; if (rd_addr !== 2'd0) begin errors++; $display("FAIL reset_rd_addr: got %0d want 0", rd_addr); end
        checks++; if (wr_weight !== '0) begin errors++; $display("FAIL reset_weight: got %h want 0", wr_weight); end
        reset = 1'b0;
        #1;
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL idle_wr_ready: got %b want 1", wr_ready); end
    endtask

    task automatic test_load_commit();
        logic [N*W-1:0] rows [N];
        int p0;
        rows = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
        p0 = prog_cnt;
        for (int i = 0; i < N; i++) begin
            wr_valid = 1'b1; wr_row = rows[i];
            #1;
            checks++; if ({wr_ready, prog_wt} !== 2'b10) begin errors++; $display("FAIL load_row%0d ready/prog: got %b want 10", i, {wr_ready, prog_wt}); end
            step();
        end
        wr_valid = 1'b0;
        #1;
        checks++; if ({prog_wt, wr_ready} !== 2'b10) begin errors++; $display("FAIL commit prog/ready: got %b want 10", {prog_wt, wr_ready}); end
        checks++; if (wr_weight !== C_EXP_A) begin errors++; $display("FAIL commit_weight: got %h want %h", wr_weight, C_EXP_A); end
        step();
        checks++; if ({prog_wt, busy} !== 2'b00) begin errors++; $display("FAIL post_commit prog/busy: got %b want 00", {prog_wt, busy}); end
        checks++; if (prog_cnt - p0 !== 1) begin errors++; $display("FAIL prog_pulses: got %0d want 1", prog_cnt - p0); end
    endtask

    task automatic test_read_sweep();
        rd_start = 1'b1;
        #1;
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL rd_start_ready: got %b want 0", wr_ready); end
        step();
        rd_start = 1'b0;
        for (int a = 0; a < N; a++) begin
            #1;
            checks++; if ({rd_valid, busy, rd_done} !== 3'b110) begin errors++; $display("FAIL sweep%0d valid/busy/done: got %b want 110", a, {rd_valid, busy, rd_done}); end
            checks++; if (rd_addr !== 2'(a)) begin errors++; $display("FAIL sweep%0d addr: got %0d want %0d", a, rd_addr, a); end
            step();
        end
        #1;
        checks++; if ({rd_done, rd_valid} !== 2'b10) begin errors++; $display("FAIL sweep_done done/valid: got %b want 10", {rd_done, rd_valid}); end
        checks++; if (rd_addr !== 2'd3) begin errors++; $display("FAIL sweep_hold_addr: got %0d want 3", rd_addr); end
        step();
        checks++; if ({rd_done, busy} !== 2'b00) begin errors++; $display("FAIL sweep_after done/busy: got %b want 00", {rd_done, busy}); end
    endtask

    task automatic test_collision();
        logic [N*W-1:0] rows [N];
        rows = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        wr_valid = 1'b1; wr_row = rows[0]; rd_start = 1'b1;
        #1;
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL collide_ready: got %b want 0", wr_ready); end
        step();
        rd_start = 1'b0;
        for (int a = 0; a < N; a++) begin
            #1;
            checks++; if ({rd_valid, wr_ready} !== 2'b10) begin errors++; $display("FAIL collide_read%0d valid/ready: got %b want 10", a, {rd_valid, wr_ready}); end
            checks++; if (wr_weight !== C_EXP_A) begin errors++; $display("FAIL collide_read%0d weight: got %h want %h", a, wr_weight, C_EXP_A); end
            step();
        end
        #1;
        checks++; if ({rd_done, wr_ready} !== 2'b11) begin errors++; $display("FAIL collide_done done/ready: got %b want 11", {rd_done, wr_ready}); end
        step();
        checks++; if (wr_weight !== {C_EXP_A[127:32], rows[0]}) begin errors++; $display("FAIL collide_row0: got %h want %h", wr_weight, {C_EXP_A[127:32], rows[0]}); end
        for (int i = 1; i < N; i++) begin
            wr_row = rows[i];
            step();
        end
        wr_valid = 1'b0;
        #1;
        checks++; if (prog_wt !== 1'b1) begin errors++; $display("FAIL collide_commit: got %b want 1", prog_wt); end
        step();
    endtask

    task automatic test_read_during_load();
        logic [N*W-1:0] rows [N];
        rows = '{32'hA3A2A1A0, 32'hB7B6B5B4, 32'hC3C2C1C0, 32'hD3D2D1D0};
        wr_valid = 1'b1;
        wr_row = rows[0]; step();
        wr_row = rows[1]; step();
        wr_valid = 1'b0; rd_start = 1'b1;
        #1;
        checks++; if ({wr_ready, busy, rd_valid} !== 3'b110) begin errors++; $display("FAIL rdl_pend ready/busy/valid: got %b want 110", {wr_ready, busy, rd_valid}); end
        step();
        rd_start = 1'b0;
        step();
        wr_valid = 1'b1; wr_row = rows[2]; step();
        wr_valid = 1'b0;
        #1;
        checks++; if ({busy, rd_valid} !== 2'b10) begin errors++; $display("FAIL rdl_gap busy/valid: got %b want 10", {busy, rd_valid}); end
        step();
        wr_valid = 1'b1; wr_row = rows[3]; step();
        wr_valid = 1'b0;
        #1;
        checks++; if ({prog_wt, rd_valid} !== 2'b10) begin errors++; $display("FAIL rdl_commit prog/valid: got %b want 10", {prog_wt, rd_valid}); end
        step();
        for (int a = 0; a < N; a++) begin
            #1;
            checks++; if ({rd_valid, rd_addr} !== {1'b1, 2'(a)}) begin errors++; $display("FAIL rdl_sweep%0d valid/addr: got %b want 1%b", a, {rd_valid, rd_addr}, 2'(a)); end
            checks++; if (wr_weight[a*32 +: 32] !== rows[a]) begin errors++; $display("FAIL rdl_sweep%0d row: got %h want %h", a, wr_weight[a*32 +: 32], rows[a]); end
            step();
        end
        #1;
        checks++; if ({rd_done, busy} !== 2'b10) begin errors++; $display("FAIL rdl_done done/busy: got %b want 10", {rd_done, busy}); end
        checks++; if (wr_weight !== C_EXP_B) begin errors++; $display("FAIL rdl_matrix: got %h want %h", wr_weight, C_EXP_B); end
        step();
    endtask

    task automatic test_back_to_back();
        int d0;
        d0 = done_cnt;
        rd_start = 1'b1;
        step();
        for (int a = 0; a < N; a++) begin
            rd_start = (a == 1) || (a == 2);
            #1;
            checks++; if (rd_addr !== 2'(a)) begin errors++; $display("FAIL b2b_first%0d addr: got %0d want %0d", a, rd_addr, a); end
            step();
        end
        rd_start = 1'b0;
        #1;
        checks++; if ({rd_done, busy, wr_ready} !== 3'b110) begin errors++; $display("FAIL b2b_mid done/busy/ready: got %b want 110", {rd_done, busy, wr_ready}); end
        step();
        for (int a = 0; a < N; a++) begin
            #1;
            checks++; if ({rd_valid, rd_addr} !== {1'b1, 2'(a)}) begin errors++; $display("FAIL b2b_second%0d valid/addr: got %b want 1%b", a, {rd_valid, rd_addr}, 2'(a)); end
            step();
        end
        #1;
        checks++; if ({rd_done, busy} !== 2'b10) begin errors++; $display("FAIL b2b_done done/busy: got %b want 10", {rd_done, busy}); end
        step();
        checks++; if ({rd_valid, busy} !== 2'b00) begin errors++; $display("FAIL b2b_idle valid/busy: got %b want 00", {rd_valid, busy}); end
        checks++; if (done_cnt - d0 !== 2) begin errors++; $display("FAIL b2b_done_pulses: got %0d want 2", done_cnt - d0); end
    endtask

    task automatic test_reset_mid_load();
        int p0;
        p0 = prog_cnt;
        wr_valid = 1'b1; wr_row = 32'h55555555;
        for (int i = 0; i < 3; i++) step();
        reset = 1'b1;
        #1;
        checks++; if ({wr_ready, busy} !== 2'b00) begin errors++; $display("FAIL rst_load_immediate ready/busy: got %b want 00", {wr_ready, busy}); end
        step();
        checks++; if ({wr_ready, prog_wt, rd_valid, rd_done, busy} !== 5'b0) begin errors++; $display("FAIL rst_load_flags: got %b want 00000", {wr_ready, prog_wt, rd_valid, rd_done, busy}); end
        checks++; if ({wr_weight, rd_addr} !== '0) begin errors++; $display("FAIL rst_load_data: got %h/%0d want 0/0", wr_weight, rd_addr); end
        reset = 1'b0; wr_row = 32'hFFFFFFFF;
        for (int i = 0; i < N; i++) begin
            #1;
            checks++; if ({wr_ready, prog_wt} !== 2'b10) begin errors++; $display("FAIL rst_reload%0d ready/prog: got %b want 10", i, {wr_ready, prog_wt}); end
            step();
        end
        wr_valid = 1'b0;
        #1;
        checks++; if (prog_wt !== 1'b1) begin errors++; $display("FAIL rst_reload_commit: got %b want 1", prog_wt); end
        checks++; if (wr_weight !== {(N*N*W){1'b1}}) begin errors++; $display("FAIL rst_reload_weight: got %h want all ones", wr_weight); end
        step();
        checks++; if (prog_cnt - p0 !== 1) begin errors++; $display("FAIL rst_reload_pulses: got %0d want 1", prog_cnt - p0); end
    endtask

    initial begin
        test_reset();
        test_load_commit();
        test_read_sweep();
        test_collision();
        test_read_during_load();
        test_back_to_back();
        test_reset_mid_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
